// File: rtl/alu_result_skid_if.sv
// Handshake bundle between the ALU (EX) and the MEM stage, passing through
// the alu_result_skid buffer. The slave modport is the buffer's view; the
// master modport is the view of whatever drives the upstream entries and
// accepts the downstream ones.
interface alu_result_skid_if #(
    parameter int WIDTH = 32,
    parameter int RDW   = 5
);
    // Upstream side (EX -> buffer)
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ResultIn;
    logic             ZIn;
    logic             VIn;
    logic             NIn;
    logic             CIn;
    logic [RDW-1:0]   RdIn;
    logic             RegWriteIn;
    logic             is_branch;
    logic [2:0]       funct3;

    // Downstream side (buffer -> MEM)
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ResultOut;
    logic [3:0]       FlagsOut;
    logic [RDW-1:0]   RdOut;
    logic             RegWriteOut;
    logic             BranchTaken;

    modport slave (
        input  in_valid, ResultIn, ZIn, VIn, NIn, CIn, RdIn, RegWriteIn,
               is_branch, funct3, out_ready,
        output in_ready, out_valid, ResultOut, FlagsOut, RdOut,
               RegWriteOut, BranchTaken
    );

    modport master (
        output in_valid, ResultIn, ZIn, VIn, NIn, CIn, RdIn, RegWriteIn,
               is_branch, funct3, out_ready,
        input  in_ready, out_valid, ResultOut, FlagsOut, RdOut,
               RegWriteOut, BranchTaken
    );
endinterface

// File: rtl/alu_result_skid.sv
// alu_result_skid: 2-entry skid buffer at the EX->MEM boundary.
// Captures the ALU result, the {Z,V,N,C} flags and the writeback tag, and
// resolves the RISC-V conditional-branch outcome at capture time.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on the same side. valid never depends on ready; in_ready is
// decoded from the state register alone, so there is no combinational path
// from out_ready to in_ready.
//
// Optional feature macro: ALU_SKID_BRANCH_EVAL_EN. When defined, branch
// outcomes are evaluated from the flags; when undefined, BranchTaken is a
// constant 0 and is_branch/funct3 are ignored.
//
// dbg_state_o exposes the occupancy state (0 EMPTY, 1 HALF, 2 FULL).
module alu_result_skid #(
    parameter int WIDTH = 32,
    parameter int RDW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    alu_result_skid_if.slave    bus,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;     // {Z,V,N,C}
        logic [RDW-1:0]   rd;
        logic             regwrite;
        logic             taken;
    } entry_t;

    state_t state_q;
    entry_t main_q;   // head entry, drives the outputs
    entry_t skid_q;   // second entry, only occupied in FULL
    entry_t cap_d;    // entry formed from the current inputs
    logic   taken_d;
    logic   in_fire;
    logic   out_fire;

`ifdef ALU_SKID_BRANCH_EVAL_EN
    // Branch outcome from subtract flags; C is "no borrow" (A >= B unsigned).
    always_comb begin
        taken_d = 1'b0;
        if (bus.is_branch) begin
            case (bus.funct3)
                3'b000:  taken_d = bus.ZIn;                   // BEQ
                3'b001:  taken_d = ~bus.ZIn;                  // BNE
                3'b100:  taken_d = bus.NIn ^ bus.VIn;         // BLT
                3'b101:  taken_d = ~(bus.NIn ^ bus.VIn);      // BGE
                3'b110:  taken_d = ~bus.CIn;                  // BLTU
                3'b111:  taken_d = bus.CIn;                   // BGEU
                default: taken_d = 1'b0;                      // 010, 011
            endcase
        end
    end
`else
    // Branch evaluation compiled out; the branch inputs are deliberately unused.
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{bus.is_branch, bus.funct3};
    assign taken_d = 1'b0;
`endif

    // Pack the upstream inputs into one entry.
    always_comb begin
        cap_d          = '0;
        cap_d.result   = bus.ResultIn;
        cap_d.flags    = {bus.ZIn, bus.VIn, bus.NIn, bus.CIn};
        cap_d.rd       = bus.RdIn;
        cap_d.regwrite = bus.RegWriteIn;
        cap_d.taken    = taken_d;
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = bus.out_valid & bus.out_ready;

    // Occupancy FSM and entry storage; flush empties without clearing data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= cap_d;
                        state_q <= HALF;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_q <= cap_d;
                    end else if (in_fire) begin
                        skid_q  <= cap_d;
                        state_q <= FULL;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= HALF;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.ResultOut   = main_q.result;
    assign bus.FlagsOut    = main_q.flags;
    assign bus.RdOut       = main_q.rd;
    assign bus.RegWriteOut = main_q.regwrite;
    assign bus.BranchTaken = main_q.taken;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_alu_result_skid.sv
// Testbench for alu_result_skid: table-driven branch/flag vectors plus
// hand-written sequences for flow, stall/skid, flush and async reset.
module tb_alu_result_skid;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] dbg_state;

    int total_checks;
    int passed_checks;

    logic [31:0] exp_q[$];

    alu_result_skid_if #(.WIDTH(32), .RDW(5)) bus ();

    alu_result_skid #(.WIDTH(32), .RDW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic [3:0]  flags;     // {Z,V,N,C}
        logic        is_br;
        logic [2:0]  f3;
        logic        taken_on;  // expected BranchTaken with evaluation enabled
    } br_vec_t;

    br_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.ResultIn   = '0;
        bus.ZIn        = 1'b0;
        bus.VIn        = 1'b0;
        bus.NIn        = 1'b0;
        bus.CIn        = 1'b0;
        bus.RdIn       = '0;
        bus.RegWriteIn = 1'b0;
        bus.is_branch  = 1'b0;
        bus.funct3     = 3'b000;
        bus.out_ready  = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic drive(input logic [31:0] res, input logic [3:0] fl,
                         input logic [4:0] rd, input logic rw,
                         input logic br, input logic [2:0] f3);
        bus.in_valid   = 1'b1;
        bus.ResultIn   = res;
        bus.ZIn        = fl[3];
        bus.VIn        = fl[2];
        bus.NIn        = fl[1];
        bus.CIn        = fl[0];
        bus.RdIn       = rd;
        bus.RegWriteIn = rw;
        bus.is_branch  = br;
        bus.funct3     = f3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"},   {31'd0, bus.out_valid},   32'd0);
        check({tag, "_in_ready"},    {31'd0, bus.in_ready},    32'd1);
        check({tag, "_result"},      bus.ResultOut,            32'd0);
        check({tag, "_flags"},       {28'd0, bus.FlagsOut},    32'd0);
        check({tag, "_rd"},          {27'd0, bus.RdOut},       32'd0);
        check({tag, "_regwrite"},    {31'd0, bus.RegWriteOut}, 32'd0);
        check({tag, "_taken"},       {31'd0, bus.BranchTaken}, 32'd0);
        check({tag, "_state"},       {30'd0, dbg_state},       32'd0);
    endtask

    initial begin
        logic exp_taken;
        total_checks  = 0;
        passed_checks = 0;

        // 3-5 -> {Z0,V0,N1,C0}; 5-5 -> {Z1,V0,N0,C1}; 0x8000_0000-1 -> {Z0,V1,N0,C1}
        vecs[0] = '{"blt_3m5",   32'hFFFF_FFFE, 4'b0010, 1'b1, 3'b100, 1'b1};
        vecs[1] = '{"bltu_3m5",  32'hFFFF_FFFE, 4'b0010, 1'b1, 3'b110, 1'b1};
        vecs[2] = '{"bgeu_3m5",  32'hFFFF_FFFE, 4'b0010, 1'b1, 3'b111, 1'b0};
        vecs[3] = '{"beq_3m5",   32'hFFFF_FFFE, 4'b0010, 1'b1, 3'b000, 1'b0};
        vecs[4] = '{"beq_5m5",   32'h0000_0000, 4'b1001, 1'b1, 3'b000, 1'b1};
        vecs[5] = '{"nobr_3m5",  32'hFFFF_FFFE, 4'b0010, 1'b0, 3'b100, 1'b0};
        vecs[6] = '{"blt_ovf",   32'h7FFF_FFFF, 4'b0101, 1'b1, 3'b100, 1'b1};
        vecs[7] = '{"bne_3m5",   32'hFFFF_FFFE, 4'b0010, 1'b1, 3'b001, 1'b1};
        vecs[8] = '{"bge_3m5",   32'hFFFF_FFFE, 4'b0010, 1'b1, 3'b101, 1'b0};
        vecs[9] = '{"f010_5m5",  32'h0000_0000, 4'b1001, 1'b1, 3'b010, 1'b0};

        // Reset at start
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        check_all_zero("rst_init");
        #2 rst = 1'b1;
        step();

        // Back-to-back flow: one entry per cycle, state stays HALF
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(i, 4'b0000, i[4:0], 1'b1, 1'b0, 3'b000);
            exp_q.push_back(i);
            step();
            check($sformatf("b2b_result_%0d", i), bus.ResultOut, exp_q.pop_front());
            check($sformatf("b2b_rd_%0d", i), {27'd0, bus.RdOut}, i);
            check($sformatf("b2b_state_%0d", i), {30'd0, dbg_state}, 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check("b2b_drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // Stall / skid
        bus.out_ready = 1'b0;
        drive(32'hAAAA_0001, 4'b0000, 5'd1, 1'b1, 1'b0, 3'b000);
        exp_q.push_back(32'hAAAA_0001);
        step();
        check("stall_first_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(32'hAAAA_0002, 4'b0000, 5'd2, 1'b1, 1'b0, 3'b000);
        exp_q.push_back(32'hAAAA_0002);
        step();
        check("stall_full_ready", {31'd0, bus.in_ready}, 32'd0);
        check("stall_full_state", {30'd0, dbg_state}, 32'd2);
        check("stall_head_hold", bus.ResultOut, exp_q[0]);
        drive(32'hAAAA_0003, 4'b0000, 5'd3, 1'b1, 1'b0, 3'b000);
        step();
        check("stall_third_blocked", {31'd0, bus.in_ready}, 32'd0);
        check("stall_head_hold2", bus.ResultOut, exp_q[0]);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stall_pop1", bus.ResultOut, exp_q.pop_front());
        step();
        check("stall_pop2", bus.ResultOut, exp_q.pop_front());
        check("stall_ready_back", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("stall_empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush collision while FULL
        bus.out_ready = 1'b0;
        drive(32'h0000_0011, 4'b0000, 5'd4, 1'b1, 1'b0, 3'b000);
        step();
        drive(32'h0000_0022, 4'b0000, 5'd5, 1'b1, 1'b0, 3'b000);
        step();
        check("flush_pre_full", {30'd0, dbg_state}, 32'd2);
        // in_ready is 0 in FULL; the 0x77 entry must still never surface
        drive(32'h0000_0077, 4'b0000, 5'd6, 1'b1, 1'b0, 3'b000);
        flush = 1'b1;
        step();
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        // Flush again from EMPTY with 0x77 offered and accepted-ready
        step();
        check("flush_collide_valid", {31'd0, bus.out_valid}, 32'd0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("flush_stays_empty", {31'd0, bus.out_valid}, 32'd0);

        // Table-driven branch / flag vectors
        for (int k = 0; k < 10; k++) begin
`ifdef ALU_SKID_BRANCH_EVAL_EN
            exp_taken = vecs[k].taken_on;
`else
            exp_taken = 1'b0;
`endif
            bus.out_ready = 1'b0;
            drive(vecs[k].result, vecs[k].flags, 5'd9, 1'b0, vecs[k].is_br, vecs[k].f3);
            step();
            bus.in_valid = 1'b0;
            check({vecs[k].name, "_valid"},  {31'd0, bus.out_valid},   32'd1);
            check({vecs[k].name, "_result"}, bus.ResultOut,            vecs[k].result);
            check({vecs[k].name, "_flags"},  {28'd0, bus.FlagsOut},    {28'd0, vecs[k].flags});
            check({vecs[k].name, "_taken"},  {31'd0, bus.BranchTaken}, {31'd0, exp_taken});
            bus.out_ready = 1'b1;
            step();
            check({vecs[k].name, "_drain"},  {31'd0, bus.out_valid},   32'd0);
        end

        // Asynchronous reset mid-stream with two entries held
        bus.out_ready = 1'b0;
        drive(32'hBBBB_0001, 4'b1111, 5'd30, 1'b1, 1'b1, 3'b000);
        step();
        drive(32'hBBBB_0002, 4'b1111, 5'd31, 1'b1, 1'b1, 3'b000);
        step();
        check("arst_pre_full", {30'd0, dbg_state}, 32'd2);
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_all_zero("arst_mid");
        #2 rst = 1'b1;
        step();
        check("arst_after_valid", {31'd0, bus.out_valid}, 32'd0);
        drive(32'h0000_0005, 4'b0000, 5'd17, 1'b1, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        check("arst_new_valid",    {31'd0, bus.out_valid},   32'd1);
        check("arst_new_result",   bus.ResultOut,            32'h0000_0005);
        check("arst_new_rd",       {27'd0, bus.RdOut},       32'd17);
        check("arst_new_regwrite", {31'd0, bus.RegWriteOut}, 32'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
